// File: rtl/ant_pkg.sv
// rtl/ant_pkg.sv - shared ant types, colour constants and cell-index width helper
package ant_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } direction_t;

  typedef enum logic {
    COLOR_WHITE = 1'b0,
    COLOR_BLACK = 1'b1
  } color_t;

  localparam logic [11:0] C_RGB_WHITE = 12'hFFF;
  localparam logic [11:0] C_RGB_BLACK = 12'h000;
  localparam logic [11:0] C_RGB_BG    = 12'h222;
  localparam logic [11:0] C_RGB_ANT   = 12'hF00;
  localparam logic [11:0] C_RGB_MARK  = 12'hFF0;

  // Bits needed to hold 0..n, since cell indices saturate one past the last cell.
  function automatic int cell_idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cell_renderer_if.sv
// rtl/cell_renderer_if.sv - cell-memory read port between renderer and cell RAM
interface cell_renderer_if;
  logic [15:0] oaddr_rd;
  logic        ird_data;

  modport master (output oaddr_rd, input ird_data);
  modport slave  (input oaddr_rd, output ird_data);
endinterface

// File: rtl/cell_pos_tracker.sv
// rtl/cell_pos_tracker.sv - divider-free pixel-to-cell tracker for one raster axis
module cell_pos_tracker
  import ant_pkg::*;
#(
  parameter int C_NUM_CELLS = 5,
  parameter int C_CELL_SIZE = 16,
  parameter int IW = cell_idx_w(C_NUM_CELLS),
  parameter int SW = (C_CELL_SIZE < 2) ? 1 : $clog2(C_CELL_SIZE)
) (
  input  logic          iclk,
  input  logic          irst,
  input  logic          iclear,
  input  logic          istep,
  output logic [SW-1:0] osub,
  output logic [IW-1:0] oidx
);

  localparam logic [SW-1:0] C_SUB_LAST = SW'(C_CELL_SIZE - 1);
  localparam logic [IW-1:0] C_IDX_MAX  = IW'(C_NUM_CELLS);

  // The index parks one past the last cell so off-grid pixels never alias back in.
  always_ff @(posedge iclk) begin
    if (irst) begin
      osub <= '0;
      oidx <= '0;
    end else if (iclear) begin
      osub <= '0;
      oidx <= '0;
    end else if (istep) begin
      if (osub == C_SUB_LAST) begin
        osub <= '0;
        if (oidx != C_IDX_MAX) begin
          oidx <= oidx + 1'b1;
        end
      end else begin
        osub <= osub + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cell_renderer.sv
// rtl/cell_renderer.sv - cell grid renderer, 3-clock pixel pipeline with ant overlay
// Optional: CELL_RENDERER_DIR_MARKER_EN draws a heading band inside the ant cell.
module cell_renderer
  import ant_pkg::*;
#(
  parameter int C_NUM_OF_CELLS_X = 5,
  parameter int C_NUM_OF_CELLS_Y = 5,
  parameter int C_CELL_WIDTH     = 16,
  parameter int C_CELL_HEIGHT    = 16,
  localparam int CW = ((C_NUM_OF_CELLS_X + C_NUM_OF_CELLS_Y) / 2 <= 1) ? 1 :
                      $clog2((C_NUM_OF_CELLS_X + C_NUM_OF_CELLS_Y) / 2)
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [10:0]           ix,
  input  logic [9:0]            iy,
  input  logic                  ide,
  input  logic                  ihsync,
  input  logic                  ivsync,
  cell_renderer_if.master       mem,
  input  logic [CW-1:0]         icur_pos_x,
  input  logic [CW-1:0]         icur_pos_y,
  input  logic [1:0]            idirection,
  output logic [11:0]           orgb,
  output logic                  ode,
  output logic                  ohsync,
  output logic                  ovsync
);

  localparam int XW  = cell_idx_w(C_NUM_OF_CELLS_X);
  localparam int YW  = cell_idx_w(C_NUM_OF_CELLS_Y);
  localparam int SXW = (C_CELL_WIDTH < 2) ? 1 : $clog2(C_CELL_WIDTH);
  localparam int SYW = (C_CELL_HEIGHT < 2) ? 1 : $clog2(C_CELL_HEIGHT);
  localparam logic [XW-1:0] C_CELLS_X = XW'(C_NUM_OF_CELLS_X);
  localparam logic [YW-1:0] C_CELLS_Y = YW'(C_NUM_OF_CELLS_Y);

  logic [XW-1:0]  column;
  logic [YW-1:0]  line;
  logic [SXW-1:0] sub_x;
  logic [SYW-1:0] sub_y;

  logic line_start;
  logic frame_start;
  assign line_start  = ide && (ix == 11'd0);
  assign frame_start = line_start && (iy == 10'd0);

  cell_pos_tracker #(
    .C_NUM_CELLS (C_NUM_OF_CELLS_X),
    .C_CELL_SIZE (C_CELL_WIDTH),
    .IW          (XW),
    .SW          (SXW)
  ) u_track_x (
    .iclk   (iclk),
    .irst   (irst),
    .iclear (line_start),
    .istep  (ide),
    .osub   (sub_x),
    .oidx   (column)
  );

  cell_pos_tracker #(
    .C_NUM_CELLS (C_NUM_OF_CELLS_Y),
    .C_CELL_SIZE (C_CELL_HEIGHT),
    .IW          (YW),
    .SW          (SYW)
  ) u_track_y (
    .iclk   (iclk),
    .irst   (irst),
    .iclear (frame_start),
    .istep  (line_start && (iy != 10'd0)),
    .osub   (sub_y),
    .oidx   (line)
  );

  logic            de0, hs0, vs0;
  logic            de1, hs1, vs1;
  logic            in_grid1, is_ant1;
  logic [CW-1:0]   lat_x, lat_y;
  direction_t      lat_dir;

  logic            in_grid;
  logic            is_ant;
  logic [15:0]     addr;

  assign in_grid = (column < C_CELLS_X) && (line < C_CELLS_Y);
  assign is_ant  = (int'(column) == int'(lat_x)) && (int'(line) == int'(lat_y));
  assign addr    = 16'(line) * 16'(C_NUM_OF_CELLS_X) + 16'(column);

  // Ant position is sampled once per frame so a mid-frame move never tears the image.
  always_ff @(posedge iclk) begin
    if (irst) begin
      de0          <= 1'b0;
      hs0          <= 1'b0;
      vs0          <= 1'b0;
      de1          <= 1'b0;
      hs1          <= 1'b0;
      vs1          <= 1'b0;
      in_grid1     <= 1'b0;
      is_ant1      <= 1'b0;
      lat_x        <= CW'(C_NUM_OF_CELLS_X / 2);
      lat_y        <= CW'(C_NUM_OF_CELLS_Y / 2);
      lat_dir      <= DIR_LEFT;
      mem.oaddr_rd <= '0;
    end else begin
      de0      <= ide;
      hs0      <= ihsync;
      vs0      <= ivsync;
      de1      <= de0;
      hs1      <= hs0;
      vs1      <= vs0;
      in_grid1 <= in_grid;
      is_ant1  <= is_ant;
      if (frame_start) begin
        lat_x   <= icur_pos_x;
        lat_y   <= icur_pos_y;
        lat_dir <= direction_t'(idirection);
      end
      if (in_grid) begin
        mem.oaddr_rd <= addr;
      end
    end
  end

  logic mark;

`ifdef CELL_RENDERER_DIR_MARKER_EN
  logic [SXW-1:0] sub_x1;
  logic [SYW-1:0] sub_y1;

  always_ff @(posedge iclk) begin
    if (irst) begin
      sub_x1 <= '0;
      sub_y1 <= '0;
    end else begin
      sub_x1 <= sub_x;
      sub_y1 <= sub_y;
    end
  end

  always_comb begin
    mark = 1'b0;
    case (lat_dir)
      DIR_UP:    mark = int'(sub_y1) < 2;
      DIR_DOWN:  mark = int'(sub_y1) >= C_CELL_HEIGHT - 2;
      DIR_LEFT:  mark = int'(sub_x1) < 2;
      DIR_RIGHT: mark = int'(sub_x1) >= C_CELL_WIDTH - 2;
      default:   mark = 1'b0;
    endcase
  end
`else
  logic unused_dir_sub;
  assign unused_dir_sub = ^{lat_dir, sub_x, sub_y};
  assign mark = 1'b0;
`endif

  always_ff @(posedge iclk) begin
    if (irst) begin
      orgb   <= 12'h000;
      ode    <= 1'b0;
      ohsync <= 1'b0;
      ovsync <= 1'b0;
    end else begin
      ode    <= de1;
      ohsync <= hs1;
      ovsync <= vs1;
      if (!de1) begin
        orgb <= C_RGB_BLACK;
      end else if (!in_grid1) begin
        orgb <= C_RGB_BG;
      end else if (is_ant1) begin
        orgb <= mark ? C_RGB_MARK : C_RGB_ANT;
      end else if (color_t'(mem.ird_data) == COLOR_BLACK) begin
        orgb <= C_RGB_BLACK;
      end else begin
        orgb <= C_RGB_WHITE;
      end
    end
  end

endmodule

// File: tb/tb_cell_renderer.sv
// tb/tb_cell_renderer.sv - directed self-checking bench for cell_renderer on a reduced raster
module tb_cell_renderer;
  import ant_pkg::*;

  localparam int H_TOT = 100;
  localparam int H_ACT = 96;
  localparam int V_TOT = 90;
  localparam int V_ACT = 88;
  localparam int NLOG  = 65536;

  logic        iclk = 1'b0;
  logic        irst;
  logic [10:0] ix;
  logic [9:0]  iy;
  logic        ide, ihsync, ivsync;
  logic [2:0]  icur_pos_x, icur_pos_y;
  logic [1:0]  idirection;
  logic [11:0] orgb;
  logic        ode, ohsync, ovsync;

  always #5 iclk = ~iclk;

  cell_renderer_if mem_if ();

  logic ram [0:31];
  assign mem_if.ird_data = (mem_if.oaddr_rd < 16'd25) ? ram[mem_if.oaddr_rd[4:0]] : 1'b0;

  cell_renderer dut (
    .iclk       (iclk),
    .irst       (irst),
    .ix         (ix),
    .iy         (iy),
    .ide        (ide),
    .ihsync     (ihsync),
    .ivsync     (ivsync),
    .mem        (mem_if.master),
    .icur_pos_x (icur_pos_x),
    .icur_pos_y (icur_pos_y),
    .idirection (idirection),
    .orgb       (orgb),
    .ode        (ode),
    .ohsync     (ohsync),
    .ovsync     (ovsync)
  );

  logic [11:0] rgb_log  [NLOG];
  logic [15:0] addr_log [NLOG];
  logic [2:0]  out_log  [NLOG];
  logic [2:0]  in_log   [NLOG];
  int          fbase    [8];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic [10:0] x, input logic [9:0] y,
                      input logic de, input logic hs, input logic vs, input logic rst);
    @(posedge iclk);
    #1;
    ix = x; iy = y; ide = de; ihsync = hs; ivsync = vs; irst = rst;
    in_log[cyc] = {de, hs, vs};
    @(negedge iclk);
    rgb_log[cyc]  = orgb;
    addr_log[cyc] = mem_if.oaddr_rd;
    out_log[cyc]  = {ode, ohsync, ovsync};
    cyc++;
  endtask

  task automatic run_frame(input int f, input int rst_x, input int rst_y,
                           input int chg_y, input logic [2:0] chg_x_pos, input logic [2:0] chg_y_pos);
    fbase[f] = cyc;
    for (int y = 0; y < V_TOT; y++) begin
      for (int x = 0; x < H_TOT; x++) begin
        if (y == chg_y && x == 0) begin
          icur_pos_x = chg_x_pos;
          icur_pos_y = chg_y_pos;
        end
        step(11'(x), 10'(y), (x < H_ACT) && (y < V_ACT), x >= H_ACT + 1, y >= V_ACT + 1,
             (x == rst_x) && (y == rst_y));
      end
    end
  endtask

  function automatic int pix(input int f, input int x, input int y);
    return fbase[f] + y * H_TOT + x;
  endfunction

  task automatic chk_rgb(input string tag, input int f, input int x, input int y, input logic [11:0] exp);
    check_eq(tag, 32'(rgb_log[pix(f, x, y) + 3]), 32'(exp));
  endtask

  task automatic chk_addr(input string tag, input int f, input int x, input int y, input logic [15:0] exp);
    check_eq(tag, 32'(addr_log[pix(f, x, y) + 2]), 32'(exp));
  endtask

  initial begin
    int k;
    int rbase;
    for (int i = 0; i < 32; i++) ram[i] = 1'b0;
    ram[7] = 1'b1;
    irst = 1'b1; ix = '0; iy = '0; ide = 1'b0; ihsync = 1'b0; ivsync = 1'b0;
    icur_pos_x = 3'd4; icur_pos_y = 3'd4; idirection = 2'd2;

    for (int i = 0; i < 4; i++) step(11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("reset_rgb", 32'(rgb_log[2]), 32'h0);
    check_eq("reset_sync", 32'(out_log[2]), 32'h0);
    check_eq("reset_addr", 32'(addr_log[2]), 32'h0);

    // Frame 0: ant parked at (4,4), cell 7 black.
    run_frame(0, -1, -1, -1, 3'd0, 3'd0);
    chk_addr("addr_0_0", 0, 0, 0, 16'd0);
    chk_addr("addr_16_0", 0, 16, 0, 16'd1);
    chk_addr("addr_0_16", 0, 0, 16, 16'd5);
    chk_addr("addr_79_79", 0, 79, 79, 16'd24);
    chk_rgb("black_32_16", 0, 32, 16, 12'h000);
    chk_rgb("black_47_31", 0, 47, 31, 12'h000);
    chk_rgb("pre_black_31_16", 0, 31, 16, 12'hFFF);
    chk_rgb("white_48_16", 0, 48, 16, 12'hFFF);
    chk_rgb("bg_80_0", 0, 80, 0, 12'h222);
    chk_addr("addr_hold_80_0", 0, 80, 0, 16'd4);
    chk_rgb("bg_40_85", 0, 40, 85, 12'h222);
    chk_rgb("ant_70_70", 0, 70, 70, 12'hF00);
    chk_rgb("blank_96_10", 0, 96, 10, 12'h000);
    check_eq("blank_de_96_10", 32'(out_log[pix(0, 96, 10) + 3]), 32'h0);

    // Frame 1: ant (2,2), moved to (0,0) at y=40 without effect this frame.
    icur_pos_x = 3'd2; icur_pos_y = 3'd2;
    run_frame(1, -1, -1, 40, 3'd0, 3'd0);
    chk_rgb("ant_40_40", 1, 40, 40, 12'hF00);
    chk_rgb("ant_47_47", 1, 47, 47, 12'hF00);
    chk_rgb("ant_after_move", 1, 40, 45, 12'hF00);
    chk_rgb("no_tear_8_8", 1, 8, 8, 12'hFFF);
    chk_rgb("no_tear_8_44", 1, 8, 44, 12'hFFF);

    // Frame 2: the move becomes visible.
    run_frame(2, -1, -1, -1, 3'd0, 3'd0);
    chk_rgb("moved_8_8", 2, 8, 8, 12'hF00);
    chk_rgb("moved_15_15", 2, 15, 15, 12'hF00);
    chk_rgb("moved_16_0", 2, 16, 0, 12'hFFF);
    chk_rgb("old_ant_40_40", 2, 40, 40, 12'hFFF);

    // Frame 3: one-clock reset at pixel (40,40).
    icur_pos_x = 3'd2; icur_pos_y = 3'd2;
    run_frame(3, 40, 40, -1, 3'd0, 3'd0);
    k = pix(3, 40, 40);
    check_eq("rst_rgb", 32'(rgb_log[k + 1]), 32'h0);
    check_eq("rst_sync", 32'(out_log[k + 1]), 32'h0);
    check_eq("rst_addr", 32'(addr_log[k + 1]), 32'h0);
    check_eq("rst_rgb_k2", 32'(rgb_log[k + 2]), 32'h0);
    check_eq("rst_de_k3", 32'(out_log[k + 3]), 32'h0);
    check_eq("rst_de_k4", 32'(out_log[k + 4]), 32'h4);
    check_eq("rst_next_line_de", 32'(out_log[pix(3, 10, 41) + 3]), 32'h4);

    // Frame 4: rendering fully restored, heading left.
    run_frame(4, -1, -1, -1, 3'd0, 3'd0);
    chk_rgb("post_rst_ant", 4, 40, 40, 12'hF00);
    chk_rgb("post_rst_black", 4, 32, 16, 12'h000);
    chk_rgb("post_rst_white", 4, 48, 16, 12'hFFF);
    chk_rgb("post_rst_bg", 4, 80, 40, 12'h222);
    chk_addr("post_rst_addr", 4, 79, 79, 16'd24);
`ifdef CELL_RENDERER_DIR_MARKER_EN
    chk_rgb("mark_left_32_32", 4, 32, 32, 12'hFF0);
    chk_rgb("mark_left_33_47", 4, 33, 47, 12'hFF0);
    chk_rgb("mark_left_34_32", 4, 34, 32, 12'hF00);
    chk_rgb("mark_left_47_47", 4, 47, 47, 12'hF00);
`else
    chk_rgb("ant_left_32_32", 4, 32, 32, 12'hF00);
    chk_rgb("ant_left_33_47", 4, 33, 47, 12'hF00);
`endif

    // Frame 5: heading down.
    idirection = 2'd1;
    run_frame(5, -1, -1, -1, 3'd0, 3'd0);
`ifdef CELL_RENDERER_DIR_MARKER_EN
    chk_rgb("mark_down_40_46", 5, 40, 46, 12'hFF0);
    chk_rgb("mark_down_40_47", 5, 40, 47, 12'hFF0);
    chk_rgb("mark_down_40_45", 5, 40, 45, 12'hF00);
    chk_rgb("mark_down_32_32", 5, 32, 32, 12'hF00);
`else
    chk_rgb("ant_down_40_46", 5, 40, 46, 12'hF00);
    chk_rgb("ant_down_32_32", 5, 32, 32, 12'hF00);
`endif

    // Random blanking and sync patterns.
    rbase = cyc;
    for (int i = 0; i < 300; i++) begin
      step(11'($urandom_range(0, 99)), 10'($urandom_range(0, 89)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 4; i++) step(11'd0, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = rbase; i < rbase + 300; i++) begin
      check_eq("sync_delay3", 32'(out_log[i + 3]), 32'(in_log[i]));
      if (out_log[i + 3][2] == 1'b0) begin
        check_eq("rgb_blank", 32'(rgb_log[i + 3]), 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
